// File: rtl/error_display_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : error_display_sequencer
// Digit-scan multiplexer with a latched, blinking "0..0C" error pattern.
// Rev    : 1.0
// ============================================================================
module error_display_sequencer #(
    parameter int                 NUM_DIGITS     = 4,
    parameter int                 CODE_W         = 4,
    parameter int                 SCAN_DIV       = 1000,
    parameter int                 BLINK_DIV      = 250000,
    parameter int                 MIN_ERR_CYCLES = 500000,
    parameter logic [CODE_W-1:0]  ZERO_CODE      = CODE_W'(4'b1101),
    parameter logic [CODE_W-1:0]  ERR_CODE       = CODE_W'(4'b1111),
    parameter logic [CODE_W-1:0]  BLANK_CODE     = CODE_W'(4'b0000)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           set_btn,
    input  logic                           reset_btn,
    input  logic [NUM_DIGITS*CODE_W-1:0]   digits_in,
    output logic [$clog2(NUM_DIGITS)-1:0]  digit_sel,
    output logic [NUM_DIGITS-1:0]          digit_en,
    output logic [CODE_W-1:0]              digit_code,
    output logic                           error_active
);

    localparam int c_sel_w   = $clog2(NUM_DIGITS);
    localparam int c_frame   = NUM_DIGITS * SCAN_DIV;
    localparam int c_scan_w  = (SCAN_DIV > 1)       ? $clog2(SCAN_DIV)       : 1;
    localparam int c_blink_w = (BLINK_DIV > 1)      ? $clog2(BLINK_DIV)      : 1;
    localparam int c_min_w   = (MIN_ERR_CYCLES > 1) ? $clog2(MIN_ERR_CYCLES) : 1;
    localparam int c_hold_w  = (c_frame > 1)        ? $clog2(c_frame)        : 1;

    localparam logic [c_sel_w-1:0]   c_sel_last   = c_sel_w'(NUM_DIGITS - 1);
    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);
    localparam logic [c_min_w-1:0]   c_min_last   = c_min_w'(MIN_ERR_CYCLES - 1);
    localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'(c_frame - 1);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_ERROR  = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t                 state_q,        state_d;
    logic [c_scan_w-1:0]    scan_cnt_q,     scan_cnt_d;
    logic [c_sel_w-1:0]     digit_sel_q,    digit_sel_d;
    logic [NUM_DIGITS-1:0]  digit_en_q,     digit_en_d;
    logic [CODE_W-1:0]      digit_code_q,   digit_code_d;
    logic                   error_active_q, error_active_d;
    logic [c_min_w-1:0]     min_cnt_q,      min_cnt_d;
    logic [c_hold_w-1:0]    hold_cnt_q,     hold_cnt_d;
    logic [c_blink_w-1:0]   blink_cnt_q,    blink_cnt_d;
    logic                   blink_off_q,    blink_off_d;

    logic                   w_both;
    logic                   w_scan_wrap;
    logic [CODE_W-1:0]      w_norm_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_NORMAL;
            scan_cnt_q     <= '0;
            digit_sel_q    <= '0;
            digit_en_q     <= NUM_DIGITS'(1);
            digit_code_q   <= BLANK_CODE;
            error_active_q <= 1'b0;
            min_cnt_q      <= '0;
            hold_cnt_q     <= '0;
            blink_cnt_q    <= '0;
            blink_off_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            scan_cnt_q     <= scan_cnt_d;
            digit_sel_q    <= digit_sel_d;
            digit_en_q     <= digit_en_d;
            digit_code_q   <= digit_code_d;
            error_active_q <= error_active_d;
            min_cnt_q      <= min_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_off_q    <= blink_off_d;
        end
    end

    always_comb begin
        w_both      = set_btn & reset_btn;
        w_scan_wrap = (scan_cnt_q == c_scan_last);
        scan_cnt_d  = w_scan_wrap ? '0 : scan_cnt_q + 1'b1;
        digit_sel_d = digit_sel_q;
        if (w_scan_wrap) begin
            digit_sel_d = (digit_sel_q == c_sel_last) ? '0 : digit_sel_q + 1'b1;
        end

        state_d    = state_q;
        min_cnt_d  = min_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_NORMAL: begin
                min_cnt_d  = '0;
                hold_cnt_d = '0;
                if (w_both) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (w_both) begin
                    min_cnt_d = '0;
                end else if (min_cnt_q != c_min_last) begin
                    min_cnt_d = min_cnt_q + 1'b1;
                end else begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                // A fresh double press outranks the end of the hold frame.
                if (w_both) begin
                    state_d   = ST_ERROR;
                    min_cnt_d = '0;
                end else if (hold_cnt_q == c_hold_last) begin
                    state_d = ST_NORMAL;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase

        if (state_q == ST_NORMAL || state_d == ST_NORMAL) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (blink_cnt_q == c_blink_last) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            blink_off_d = blink_off_q;
        end

        w_norm_code = BLANK_CODE;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel_d == c_sel_w'(i)) begin
                w_norm_code = digits_in[i*CODE_W +: CODE_W];
            end
        end

        // Codes are computed for the upcoming digit so code and select move together.
        if (state_d == ST_NORMAL) begin
            digit_code_d = w_norm_code;
        end else if (blink_off_d) begin
            digit_code_d = BLANK_CODE;
        end else if (digit_sel_d == c_sel_last) begin
            digit_code_d = ERR_CODE;
        end else begin
            digit_code_d = ZERO_CODE;
        end

        digit_en_d     = NUM_DIGITS'(1) << digit_sel_d;
        error_active_d = (state_d != ST_NORMAL);
    end

    assign digit_sel    = digit_sel_q;
    assign digit_en     = digit_en_q;
    assign digit_code   = digit_code_q;
    assign error_active = error_active_q;

endmodule
`default_nettype wire

// File: tb/tb_error_display_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_error_display_sequencer
// Directed self-checking bench for error_display_sequencer.
// Rev    : 1.0
// ============================================================================
module tb_error_display_sequencer;

    localparam int ND    = 4;
    localparam int CW    = 4;
    localparam int SD    = 2;
    localparam int BD    = 8;
    localparam int ME    = 20;
    localparam int FRAME = ND * SD;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              set_btn;
    logic              reset_btn;
    logic [ND*CW-1:0]  digits_in;
    logic [1:0]        digit_sel;
    logic [ND-1:0]     digit_en;
    logic [CW-1:0]     digit_code;
    logic              error_active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit m_err  = 1'b0;
    int e      = 0;
    int last_hi = 0;

    error_display_sequencer #(
        .NUM_DIGITS     (ND),
        .CODE_W         (CW),
        .SCAN_DIV       (SD),
        .BLINK_DIV      (BD),
        .MIN_ERR_CYCLES (ME),
        .ZERO_CODE      (4'b1101),
        .ERR_CODE       (4'b1111),
        .BLANK_CODE     (4'b0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_btn      (set_btn),
        .reset_btn    (reset_btn),
        .digits_in    (digits_in),
        .digit_sel    (digit_sel),
        .digit_en     (digit_en),
        .digit_code   (digit_code),
        .error_active (error_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_reset_values();
        check("rst_digit_sel",    32'(digit_sel),    32'd0);
        check("rst_digit_en",     32'(digit_en),     32'h1);
        check("rst_digit_code",   32'(digit_code),   32'h0);
        check("rst_error_active", 32'(error_active), 32'd0);
    endtask

    // Expected outputs: select from edges since reset, code from mode and blink age.
    task automatic check_all();
        int         sel;
        logic [3:0] code;
        sel = (cyc / SD) % ND;
        if (!m_err)                  code = digits_in[sel*CW +: CW];
        else if (((e / BD) % 2) == 1) code = 4'h0;
        else if (sel == ND - 1)      code = 4'hF;
        else                         code = 4'hD;
        check("digit_sel",    32'(digit_sel),    32'(sel));
        check("digit_en",     32'(digit_en),     32'(1 << sel));
        check("digit_code",   32'(digit_code),   32'(code));
        check("error_active", 32'(error_active), 32'(m_err));
    endtask

    task automatic step(input logic s, input logic r);
        set_btn   = s;
        reset_btn = r;
        @(posedge clk);
        #1;
        cyc++;
        if (m_err) begin
            e++;
            if (s & r) last_hi = e;
            else if (e >= last_hi + ME + FRAME) m_err = 1'b0;
        end else if (s & r) begin
            m_err   = 1'b1;
            e       = 0;
            last_hi = 0;
        end
        check_all();
    endtask

    initial begin
        rst_n     = 1'b0;
        set_btn   = 1'b0;
        reset_btn = 1'b0;
        digits_in = 16'h4321;
        #12;
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;

        // Plain scan after reset
        repeat (9) step(1'b0, 1'b0);

        // Single-cycle double press, full blink on/off and recovery
        step(1'b1, 1'b1);
        repeat (32) step(1'b0, 1'b0);

        // Buttons held 50 cycles keep the min timer reloading
        repeat (50) step(1'b1, 1'b1);
        repeat (32) step(1'b0, 1'b0);

        // Single buttons are not an error
        digits_in = 16'hA5C7;
        repeat (5) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1);

        // Re-press during HOLD restarts the min timer
        step(1'b1, 1'b1);
        repeat (21) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        repeat (32) step(1'b0, 1'b0);

        // Asynchronous reset in the middle of ERROR
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        m_err = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        cyc   = 0;
        repeat (6) step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
